// File: rtl/psk_pkg.sv
// Shared types, mode/state encodings and saturation helpers for the
// PSK error-detect front end.
package psk_pkg;

   localparam int PSK_MAXW = 64;

   localparam logic MODE_BPSK = 1'b1;
   localparam logic MODE_QPSK = 1'b0;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_BLANK = 1'b1
   } psk_state_e;

   // Operands are sign-extended WIDTH-bit words, so the 64-bit sum
   // cannot wrap; the result is clamped to the w-bit signed range.
   function automatic logic signed [PSK_MAXW-1:0] sat_add(
      input logic signed [PSK_MAXW-1:0] a,
      input logic signed [PSK_MAXW-1:0] b,
      input int                         w
   );
      logic signed [PSK_MAXW-1:0] s;
      logic signed [PSK_MAXW-1:0] hi;
      logic signed [PSK_MAXW-1:0] lo;
      s  = a + b;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (s > hi)
         return hi;
      else if (s < lo)
         return lo;
      else
         return s;
   endfunction

   // Negating the most negative w-bit value yields the most positive.
   function automatic logic signed [PSK_MAXW-1:0] sat_neg(
      input logic signed [PSK_MAXW-1:0] a,
      input int                         w
   );
      logic signed [PSK_MAXW-1:0] hi;
      logic signed [PSK_MAXW-1:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (a == lo)
         return hi;
      else
         return -a;
   endfunction

endpackage

// File: rtl/psk_iq_precondition.sv
// Registered I/Q pre-conditioning for the BPSK/QPSK detectors.
// Ports: is_bpsk mode, in_I/in_Q samples+valids, out_I/out_Q to detectors.
import psk_pkg::*;

module psk_iq_precondition #(
   parameter int WIDTH      = 16,
   parameter int QPSK_SHIFT = 6
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    is_bpsk,
   input  logic signed [WIDTH-1:0] in_I_tdata,
   input  logic                    in_I_tvalid,
   input  logic signed [WIDTH-1:0] in_Q_tdata,
   input  logic                    in_Q_tvalid,
   output logic signed [WIDTH-1:0] out_I_tdata,
   output logic                    out_I_tvalid,
   output logic signed [WIDTH-1:0] out_Q_tdata,
   output logic                    out_Q_tvalid
);

   logic signed [WIDTH-1:0] r_out_i;
   logic signed [WIDTH-1:0] r_out_q;
   logic signed [WIDTH-1:0] w_nxt_i;
   logic signed [WIDTH-1:0] w_nxt_q;

   function automatic logic signed [WIDTH-1:0] f_bpsk(
      input logic signed [WIDTH-1:0] a,
      input logic signed [WIDTH-1:0] b,
      input logic                    sub
   );
      logic signed [PSK_MAXW-1:0] bb;
      bb = sub ? -PSK_MAXW'(b) : PSK_MAXW'(b);
      return WIDTH'(sat_add(PSK_MAXW'(a), bb, WIDTH));
   endfunction

   function automatic logic signed [WIDTH-1:0] f_qpsk(
      input logic signed [WIDTH-1:0] x,
      input logic                    neg
   );
      logic signed [PSK_MAXW-1:0] t;
      t = neg ? sat_neg(PSK_MAXW'(x), WIDTH) : PSK_MAXW'(x);
      t = t >>> QPSK_SHIFT;
      return WIDTH'(t);
   endfunction

   always_comb begin
      w_nxt_i = '0;
      w_nxt_q = '0;
      if (is_bpsk == MODE_QPSK) begin
         w_nxt_i = f_qpsk(in_I_tdata, in_Q_tdata < 0);
         w_nxt_q = f_qpsk(in_Q_tdata, in_I_tdata < 0);
      end else begin
         w_nxt_i = f_bpsk(in_I_tdata, in_Q_tdata, 1'b0);
         w_nxt_q = f_bpsk(in_I_tdata, in_Q_tdata, 1'b1);
      end
      if (!in_I_tvalid)
         w_nxt_i = '0;
      if (!in_Q_tvalid)
         w_nxt_q = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_i <= '0;
         r_out_q <= '0;
      end else begin
         r_out_i <= w_nxt_i;
         r_out_q <= w_nxt_q;
      end
   end

   // The loop filter is kept primed: outputs are always valid.
   assign out_I_tdata  = r_out_i;
   assign out_Q_tdata  = r_out_q;
   assign out_I_tvalid = 1'b1;
   assign out_Q_tvalid = 1'b1;

endmodule

// File: rtl/psk_error_detect_ctrl.sv
// Costas-loop phase-error front end: I/Q pre-conditioning, error mux,
// post-mode-change blanking FSM and optional clamp (ERROR_CLAMP_EN).
import psk_pkg::*;

module psk_error_detect_ctrl #(
   parameter int WIDTH        = 16,
   parameter int QPSK_SHIFT   = 6,
   parameter int BLANK_CYCLES = 4,
   parameter int ERR_LIMIT    = 2**(WIDTH-2)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    is_bpsk,
   input  logic signed [WIDTH-1:0] in_I_tdata,
   input  logic                    in_I_tvalid,
   input  logic signed [WIDTH-1:0] in_Q_tdata,
   input  logic                    in_Q_tvalid,
   output logic signed [WIDTH-1:0] out_I_tdata,
   output logic                    out_I_tvalid,
   output logic signed [WIDTH-1:0] out_Q_tdata,
   output logic                    out_Q_tvalid,
   input  logic signed [WIDTH-1:0] error_bpsk_tdata,
   input  logic                    error_bpsk_tvalid,
   input  logic signed [WIDTH-1:0] error_qpsk_tdata,
   input  logic                    error_qpsk_tvalid,
   output logic signed [WIDTH-1:0] error_tdata,
   output logic                    error_tvalid,
   output logic                    is_bpsk_delayed,
   output logic                    blanking,
   output logic                    clamp_active
);

   localparam int CW = (BLANK_CYCLES < 1) ? 1
                                          : $clog2(BLANK_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(BLANK_CYCLES);
   localparam psk_state_e ST_RST = (BLANK_CYCLES == 0) ? ST_RUN
                                                       : ST_BLANK;

   if (ERR_LIMIT < 1 || ERR_LIMIT > 2**(WIDTH-1) - 1) begin : g_bad_lim
      $error("ERR_LIMIT out of range");
   end
   if (QPSK_SHIFT < 0 || QPSK_SHIFT >= WIDTH) begin : g_bad_shift
      $error("QPSK_SHIFT out of range");
   end

   psk_state_e              r_state;
   psk_state_e              w_state_nxt;
   logic [CW-1:0]           r_cnt;
   logic [CW-1:0]           w_cnt_nxt;
   logic                    r_is_bpsk_d;
   logic signed [WIDTH-1:0] r_err;
   logic                    r_err_vld;
   logic                    r_clamp;
   logic signed [WIDTH-1:0] w_sel;
   logic                    w_sel_vld;
   logic                    w_chg;
   logic signed [WIDTH-1:0] w_blk;
   logic signed [WIDTH-1:0] w_err_nxt;
   logic                    w_clamp_nxt;

   psk_iq_precondition #(
      .WIDTH      (WIDTH),
      .QPSK_SHIFT (QPSK_SHIFT)
   ) u_iq (
      .clk          (clk),
      .rst_n        (rst_n),
      .is_bpsk      (is_bpsk),
      .in_I_tdata   (in_I_tdata),
      .in_I_tvalid  (in_I_tvalid),
      .in_Q_tdata   (in_Q_tdata),
      .in_Q_tvalid  (in_Q_tvalid),
      .out_I_tdata  (out_I_tdata),
      .out_I_tvalid (out_I_tvalid),
      .out_Q_tdata  (out_Q_tdata),
      .out_Q_tvalid (out_Q_tvalid)
   );

   // The delayed mode matches the detectors' one-cycle latency.
   assign w_sel     = (r_is_bpsk_d == MODE_BPSK) ? error_bpsk_tdata
                                                 : error_qpsk_tdata;
   assign w_sel_vld = (r_is_bpsk_d == MODE_BPSK) ? error_bpsk_tvalid
                                                 : error_qpsk_tvalid;
   assign w_chg     = (is_bpsk != r_is_bpsk_d);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (BLANK_CYCLES == 0) begin
         w_state_nxt = ST_RUN;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_chg) begin
                  w_state_nxt = ST_BLANK;
                  w_cnt_nxt   = CNT_LOAD;
               end
            end
            ST_BLANK: begin
               // A reload wins over the final decrement.
               if (w_chg) begin
                  w_cnt_nxt = CNT_LOAD;
               end else if (w_sel_vld) begin
                  w_cnt_nxt = r_cnt - 1'b1;
                  if (r_cnt == CW'(1))
                     w_state_nxt = ST_RUN;
               end
            end
            default: begin
               w_state_nxt = ST_RUN;
            end
         endcase
      end
   end

   assign w_blk = (w_sel_vld && r_state == ST_RUN) ? w_sel : '0;

`ifdef ERROR_CLAMP_EN
   localparam logic signed [WIDTH-1:0] LIM_P = WIDTH'(ERR_LIMIT);
   localparam logic signed [WIDTH-1:0] LIM_N = -LIM_P;

   always_comb begin
      w_err_nxt   = w_blk;
      w_clamp_nxt = 1'b0;
      if (w_blk > LIM_P) begin
         w_err_nxt   = LIM_P;
         w_clamp_nxt = 1'b1;
      end else if (w_blk < LIM_N) begin
         w_err_nxt   = LIM_N;
         w_clamp_nxt = 1'b1;
      end
   end
`else
   assign w_err_nxt   = w_blk;
   assign w_clamp_nxt = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_RST;
         r_cnt       <= CNT_LOAD;
         r_is_bpsk_d <= 1'b1;
         r_err       <= '0;
         r_err_vld   <= 1'b0;
         r_clamp     <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_is_bpsk_d <= is_bpsk;
         r_err       <= w_err_nxt;
         r_err_vld   <= w_sel_vld;
         r_clamp     <= w_clamp_nxt;
      end
   end

   assign error_tdata     = r_err;
   assign error_tvalid    = r_err_vld;
   assign is_bpsk_delayed = r_is_bpsk_d;
   assign blanking        = (r_state == ST_BLANK);
   assign clamp_active    = r_clamp;

endmodule

// File: doc/psk_error_detect_ctrl.md
Name: psk_error_detect_ctrl

Overview:
Parametrised successor to the Costas-loop phase-error front end. It pre-processes NCO-mixed I/Q for the BPSK or QPSK error detector and multiplexes the detector outputs into a single error stream for the loop filter. New behaviour compared with the previous generation:
- saturating arithmetic;
- a configurable QPSK scaling shift;
- a registered error path;
- a blanking state machine that zeroes the loop error for a programmable number of valid samples after reset or after any modulation-mode change, so the loop filter is not kicked by detector transients.

Parameters:
WIDTH, 16, sample and error word width (two's complement)
QPSK_SHIFT, 6, arithmetic right shift applied to QPSK products to match BPSK scale (0..WIDTH-1)
BLANK_CYCLES, 4, number of valid error samples forced to zero after reset or a mode change; 0 disables blanking
ERR_LIMIT, 2**(WIDTH-2), clamp magnitude; used only with ERROR_CLAMP_EN

Ports:
clk  in  1  system clock; all state on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
is_bpsk  in  1  mode select: 1 = BPSK, 0 = QPSK
in_I_tdata / in_I_tvalid  in  WIDTH / 1  mixed I sample and its valid
in_Q_tdata / in_Q_tvalid  in  WIDTH / 1  mixed Q sample and its valid
out_I_tdata / out_I_tvalid  out  WIDTH / 1  pre-processed I to the detectors
out_Q_tdata / out_Q_tvalid  out  WIDTH / 1  pre-processed Q to the detectors
error_bpsk_tdata / error_bpsk_tvalid  in  WIDTH / 1  BPSK detector output
error_qpsk_tdata / error_qpsk_tvalid  in  WIDTH / 1  QPSK detector output
error_tdata / error_tvalid  out  WIDTH / 1  selected, blanked (and optionally clamped) loop error
is_bpsk_delayed  out  1  is_bpsk registered once; selects the error source
blanking  out  1  high while the FSM is in BLANK
clamp_active  out  1  error clamped this cycle; tied 0 without ERROR_CLAMP_EN

Behaviour:
- Single clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - out_I_tdata = out_Q_tdata = 0, and out_I_tvalid = out_Q_tvalid = 1, so the loop filter is primed.
  - is_bpsk_delayed = 1, error_tdata = 0, error_tvalid = 0, clamp_active = 0.
  - FSM = BLANK, counter = BLANK_CYCLES, blanking = 1 (0 if BLANK_CYCLES = 0, in which case the FSM resets to RUN).
- I/Q stage, latency 1. out_*_tvalid is constant 1 after reset. is_bpsk_delayed <= is_bpsk every cycle.
  - BPSK: out_I = sat(I+Q), out_Q = sat(I−Q). Sums are computed at WIDTH+1 bits and saturated to [−2^(WIDTH-1), 2^(WIDTH-1)−1].
  - QPSK: out_I = (Q<0 ? sneg(I) : I) >>> QPSK_SHIFT; out_Q = (I<0 ? sneg(Q) : Q) >>> QPSK_SHIFT. sneg is saturating negate: sneg(−2^(WIDTH-1)) = 2^(WIDTH-1)−1.
  - out_I_tdata = 0 when in_I_tvalid = 0; out_Q_tdata = 0 when in_Q_tvalid = 0.
- Error path, latency 1:
  - sel = is_bpsk_delayed ? bpsk : qpsk.
  - error_tvalid <= sel_tvalid.
  - error_tdata <= (sel_tvalid && state == RUN) ? sel_tdata : 0.
- FSM, states RUN and BLANK:
  - Mode change is detected as is_bpsk != is_bpsk_delayed.
  - RUN → BLANK on a mode change; counter loads BLANK_CYCLES.
  - In BLANK, the counter decrements on each cycle with sel_tvalid = 1. When counter = 1 and sel_tvalid = 1, go to RUN; the next valid sample passes unblanked.
  - A mode change while in BLANK reloads the counter and stays in BLANK.
  - A mode change coinciding with the final decrement takes priority: the FSM stays in BLANK with the counter reloaded.
  - BLANK_CYCLES = 0: the FSM stays in RUN permanently and mode changes are ignored.
  - Counter width is $clog2(BLANK_CYCLES+1), minimum 1.
- rst_n asserted mid-operation immediately forces all reset values, with no completion of in-flight samples.

Optional Feature:
ERROR_CLAMP_EN
- Defined: after blanking, error_tdata is clamped to [−ERR_LIMIT, +ERR_LIMIT]. clamp_active is registered alongside error_tdata and is 1 whenever clamping changed the value. Latency is unchanged.
- Undefined: no clamp, ERR_LIMIT is unused, and clamp_active is constant 0.

Decomposition:
- Shared package psk_pkg:
  - mode encoding constants MODE_BPSK = 1'b1, MODE_QPSK = 1'b0;
  - FSM state constants ST_RUN, ST_BLANK;
  - saturation helper functions sat_add and sat_neg, parametrised on WIDTH.
- One sub-module, psk_iq_precondition, is natural: the registered BPSK/QPSK I/Q stage. The FSM and error mux stay in the top.

Test Plan (WIDTH=16, QPSK_SHIFT=6, BLANK_CYCLES=4):
1. Reset: hold rst_n=0 mid-stream → same cycle out_I_tvalid=1, out_I_tdata=0, is_bpsk_delayed=1, error_tvalid=0, blanking=1.
2. BPSK nominal: I=1000, Q=200, both valid → next cycle out_I_tdata=1200, out_Q_tdata=800.
3. BPSK saturation: I=30000, Q=10000 → out_I_tdata=32767. Then I=−30000, Q=10000 → out_Q_tdata=−32768.
4. QPSK: I=−6400, Q=−128 → out_I_tdata=100, out_Q_tdata=2. Then I=−32768, Q=−1 → out_I_tdata=511.
5. Mode switch: error_qpsk_tdata=500 valid every cycle, is_bpsk 1→0 in RUN → blanking=1 and error_tdata=0 for exactly 4 valid samples, then 500. A second toggle during blanking restarts the count at 4.
6. ERROR_CLAMP_EN defined, ERR_LIMIT=1000: error 5000 → error_tdata=1000, clamp_active=1; error −5000 → −1000; error 999 → 999, clamp_active=0.
